// File: rtl/snn_sched_pkg.sv
// Shared definitions for the SNN step scheduler: default sizing,
// state encoding and step-length derivation.
package snn_sched_pkg;

    localparam int unsigned NUM_LAYERS_DEF    = 2;
    localparam int unsigned NEURON_CYCLES_DEF = 8;
    localparam int unsigned DIV_W_DEF         = 8;
    localparam int unsigned STEP_CNT_W_DEF    = 16;

    // Index width for a count of n items; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Cycles from CAPTURE through COMMIT inclusive.
    function automatic int unsigned step_len(input int unsigned layers,
                                             input int unsigned cycles);
        return 2 + layers * cycles;
    endfunction

    localparam int unsigned STEP_LEN = step_len(NUM_LAYERS_DEF, NEURON_CYCLES_DEF);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_LAYER   = 3'd3,
        ST_COMMIT  = 3'd4
    } sched_state_e;

endpackage

// File: rtl/snn_step_scheduler_sync_2ff.sv
// Two-flop synchronizer for level signals crossing into the core clock domain.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/snn_step_scheduler.sv
// SNN time-step scheduler: paces steps with a programmable divider and
// sequences spike capture, per-layer/per-neuron evaluation and state commit.
// Optional macro SCHED_SINGLE_STEP_EN adds step_req_async for one-shot
// steps launched from IDLE.
module snn_step_scheduler
    import snn_sched_pkg::*;
#(
    parameter int unsigned NUM_LAYERS    = NUM_LAYERS_DEF,
    parameter int unsigned NEURON_CYCLES = NEURON_CYCLES_DEF,
    parameter int unsigned DIV_W         = DIV_W_DEF,
    parameter int unsigned STEP_CNT_W    = STEP_CNT_W_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_ready_async,
    input  logic                             spike_ready_async,
`ifdef SCHED_SINGLE_STEP_EN
    input  logic                             step_req_async,
`endif
    input  logic [DIV_W-1:0]                 clk_div,
    output logic                             busy,
    output logic                             spike_capture,
    output logic                             layer_en,
    output logic [idx_w(NUM_LAYERS)-1:0]     layer_sel,
    output logic [idx_w(NEURON_CYCLES)-1:0]  neuron_idx,
    output logic                             state_commit,
    output logic [STEP_CNT_W-1:0]            step_count,
    output logic                             overrun
);

    localparam int unsigned LAYER_W  = idx_w(NUM_LAYERS);
    localparam int unsigned NEURON_W = idx_w(NEURON_CYCLES);
    localparam logic [LAYER_W-1:0]  LAST_LAYER  = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [NEURON_W-1:0] LAST_NEURON = NEURON_W'(NEURON_CYCLES - 1);

    sched_state_e            state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [LAYER_W-1:0]      layer_q, layer_d;
    logic [NEURON_W-1:0]     neuron_q, neuron_d;
    logic [STEP_CNT_W-1:0]   step_count_q, step_count_d;
    logic                    overrun_q, overrun_d;
    logic                    busy_q, busy_d;
    logic                    capture_q, capture_d;
    logic                    layer_en_q, layer_en_d;
    logic                    commit_q, commit_d;

    logic                    cfg_sync;
    logic                    spike_sync;
    logic                    run_en_c;
    logic                    tick_c;

    // SPI-domain ready flags into the core domain.
    sync_2ff #(.WIDTH(1)) u_sync_cfg (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cfg_ready_async),
        .q_o   (cfg_sync)
    );

    sync_2ff #(.WIDTH(1)) u_sync_spike (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (spike_ready_async),
        .q_o   (spike_sync)
    );

    assign run_en_c = cfg_sync & spike_sync;

`ifdef SCHED_SINGLE_STEP_EN
    logic req_sync;
    logic req_prev_q;
    logic req_edge_c;
    logic single_q, single_d;

    sync_2ff #(.WIDTH(1)) u_sync_req (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (step_req_async),
        .q_o   (req_sync)
    );

    // Previous synchronized request level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_prev_q <= 1'b0;
        end else begin
            req_prev_q <= req_sync;
        end
    end

    assign req_edge_c = req_sync & ~req_prev_q;
`endif

    // Divider expires on zero; it only runs once the scheduler has left IDLE.
    assign tick_c = (state_q != ST_IDLE) && (div_q == '0);

    // State and datapath-control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            layer_q      <= '0;
            neuron_q     <= '0;
            step_count_q <= '0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            capture_q    <= 1'b0;
            layer_en_q   <= 1'b0;
            commit_q     <= 1'b0;
`ifdef SCHED_SINGLE_STEP_EN
            single_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            layer_q      <= layer_d;
            neuron_q     <= neuron_d;
            step_count_q <= step_count_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            capture_q    <= capture_d;
            layer_en_q   <= layer_en_d;
            commit_q     <= commit_d;
`ifdef SCHED_SINGLE_STEP_EN
            single_q     <= single_d;
`endif
        end
    end

    // Next-state, divider, index counters and registered output decode.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        layer_d      = '0;
        neuron_d     = '0;
        step_count_d = step_count_q;
        overrun_d    = overrun_q;
`ifdef SCHED_SINGLE_STEP_EN
        single_d     = single_q;
`endif

        // IDLE keeps the divider primed; elsewhere it counts down and reloads.
        if (state_q == ST_IDLE || tick_c) begin
            div_d = clk_div;
        end else begin
            div_d = div_q - DIV_W'(1);
        end

        // A tick that cannot start a step is dropped and flagged.
        if (tick_c && state_q != ST_WAIT) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (run_en_c) begin
                    state_d   = ST_WAIT;
                    overrun_d = 1'b0;
                end
`ifdef SCHED_SINGLE_STEP_EN
                else if (cfg_sync && req_edge_c) begin
                    state_d  = ST_CAPTURE;
                    single_d = 1'b1;
                end
`endif
            end
            ST_WAIT: begin
                if (!run_en_c) begin
                    state_d = ST_IDLE;
                end else if (tick_c) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_LAYER;
            end
            ST_LAYER: begin
                if (neuron_q == LAST_NEURON) begin
                    if (layer_q == LAST_LAYER) begin
                        state_d      = ST_COMMIT;
                        step_count_d = step_count_q + STEP_CNT_W'(1);
                    end else begin
                        layer_d = layer_q + LAYER_W'(1);
                    end
                end else begin
                    neuron_d = neuron_q + NEURON_W'(1);
                    layer_d  = layer_q;
                end
            end
            ST_COMMIT: begin
                state_d = run_en_c ? ST_WAIT : ST_IDLE;
`ifdef SCHED_SINGLE_STEP_EN
                if (single_q) begin
                    state_d = ST_IDLE;
                end
                single_d = 1'b0;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d == ST_CAPTURE) || (state_d == ST_LAYER) ||
                     (state_d == ST_COMMIT);
        capture_d  = (state_d == ST_CAPTURE);
        layer_en_d = (state_d == ST_LAYER);
        commit_d   = (state_d == ST_COMMIT);
    end

    assign busy          = busy_q;
    assign spike_capture = capture_q;
    assign layer_en      = layer_en_q;
    assign layer_sel     = layer_q;
    assign neuron_idx    = neuron_q;
    assign state_commit  = commit_q;
    assign step_count    = step_count_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Directed self-checking bench for snn_step_scheduler (default sizing).
module tb_snn_step_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_ready_async = 1'b0;
    logic        spike_ready_async = 1'b0;
    logic [7:0]  clk_div = 8'd20;
`ifdef SCHED_SINGLE_STEP_EN
    logic        step_req_async = 1'b0;
`endif
    logic        busy;
    logic        spike_capture;
    logic        layer_en;
    logic [0:0]  layer_sel;
    logic [2:0]  neuron_idx;
    logic        state_commit;
    logic [15:0] step_count;
    logic        overrun;

    int n_cmp;
    int n_fail;
    int cyc;
    int cap_q[$];
    int com_q[$];
    int layer_cnt;
    int busy_cnt;

    snn_step_scheduler dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_ready_async   (cfg_ready_async),
        .spike_ready_async (spike_ready_async),
`ifdef SCHED_SINGLE_STEP_EN
        .step_req_async    (step_req_async),
`endif
        .clk_div           (clk_div),
        .busy              (busy),
        .spike_capture     (spike_capture),
        .layer_en          (layer_en),
        .layer_sel         (layer_sel),
        .neuron_idx        (neuron_idx),
        .state_commit      (state_commit),
        .step_count        (step_count),
        .overrun           (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle and record output events 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (spike_capture === 1'b1) cap_q.push_back(cyc);
        if (state_commit === 1'b1)  com_q.push_back(cyc);
        if (layer_en === 1'b1)      layer_cnt++;
        if (busy === 1'b1)          busy_cnt++;
    endtask

    task automatic clear_rec();
        cyc = 0;
        cap_q.delete();
        com_q.delete();
        layer_cnt = 0;
        busy_cnt  = 0;
    endtask

    task automatic do_reset(input logic [7:0] div);
        rst_n             = 1'b0;
        cfg_ready_async   = 1'b0;
        spike_ready_async = 1'b0;
        clk_div           = div;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_rec();
    endtask

    task automatic test_reset();
        logic [24:0] obs;
        rst_n = 1'b0;
        cfg_ready_async   = 1'b1;
        spike_ready_async = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        obs = {busy, spike_capture, layer_en, state_commit, overrun, layer_sel, neuron_idx, step_count};
        n_cmp++;
        if (obs !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        n_cmp++;
        if (dut.state_q !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected 0", dut.state_q);
        end
    endtask

    task automatic test_start();
        do_reset(8'd20);
        cfg_ready_async   = 1'b1;
        spike_ready_async = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (dut.state_q !== 3'd0) begin
            n_fail++;
            $display("FAIL start_idle_c2: state %0d expected 0", dut.state_q);
        end
        tick();
        n_cmp++;
        if (dut.state_q !== 3'd1) begin
            n_fail++;
            $display("FAIL start_wait_c3: state %0d expected 1", dut.state_q);
        end
        while (cap_q.size() == 0 && cyc < 60) tick();
        n_cmp++;
        if (cap_q.size() != 1 || cap_q[0] != 24) begin
            n_fail++;
            $display("FAIL start_first_capture: count %0d cycle %0d expected 1 at 24",
                     cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : -1);
        end
        for (int k = 0; k < 16; k++) begin
            tick();
            n_cmp++;
            if (layer_en !== 1'b1 || neuron_idx !== 3'(k % 8) || layer_sel !== 1'(k / 8)) begin
                n_fail++;
                $display("FAIL start_layer_%0d: en %b layer %0d neuron %0d expected 1 %0d %0d",
                         k, layer_en, layer_sel, neuron_idx, k / 8, k % 8);
            end
        end
        tick();
        n_cmp++;
        if (state_commit !== 1'b1 || busy !== 1'b1 || layer_en !== 1'b0 || neuron_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL start_commit: commit %b busy %b en %b neuron %0d expected 1 1 0 0",
                     state_commit, busy, layer_en, neuron_idx);
        end
        tick();
        n_cmp++;
        if (state_commit !== 1'b0 || busy !== 1'b0 || step_count !== 16'd1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL start_after: commit %b busy %b steps %0d overrun %b expected 0 0 1 0",
                     state_commit, busy, step_count, overrun);
        end
        n_cmp++;
        if (busy_cnt != 18 || com_q.size() != 1) begin
            n_fail++;
            $display("FAIL start_busy_len: busy %0d commits %0d expected 18 1", busy_cnt, com_q.size());
        end
    endtask

    // Continues from test_start: captures every 21 cycles up to ten steps.
    task automatic test_periodic();
        while (cyc < 231) tick();
        n_cmp++;
        if (cap_q.size() != 10 || com_q.size() != 10) begin
            n_fail++;
            $display("FAIL periodic_counts: captures %0d commits %0d expected 10 10",
                     cap_q.size(), com_q.size());
        end
        for (int i = 1; i < 10 && i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] - cap_q[i-1] != 21) begin
                n_fail++;
                $display("FAIL periodic_spacing_%0d: got %0d expected 21", i, cap_q[i] - cap_q[i-1]);
            end
        end
        n_cmp++;
        if (step_count !== 16'd10 || overrun !== 1'b0 || busy_cnt != 180) begin
            n_fail++;
            $display("FAIL periodic_end: steps %0d overrun %b busy %0d expected 10 0 180",
                     step_count, overrun, busy_cnt);
        end
    endtask

    task automatic test_overrun();
        do_reset(8'd5);
        cfg_ready_async   = 1'b1;
        spike_ready_async = 1'b1;
        while (cyc < 100) begin
            tick();
            if (cyc == 9) begin
                n_cmp++;
                if (overrun !== 1'b0 || spike_capture !== 1'b1) begin
                    n_fail++;
                    $display("FAIL overrun_first_capture: ovr %b cap %b expected 0 1", overrun, spike_capture);
                end
            end
            if (cyc == 27) begin
                n_cmp++;
                if (overrun !== 1'b1) begin
                    n_fail++;
                    $display("FAIL overrun_set: got %b expected 1", overrun);
                end
            end
        end
        n_cmp++;
        if (cap_q.size() != 4 || com_q.size() != 4 || layer_cnt != 64) begin
            n_fail++;
            $display("FAIL overrun_counts: caps %0d commits %0d layer %0d expected 4 4 64",
                     cap_q.size(), com_q.size(), layer_cnt);
        end
        for (int i = 0; i < 4 && i < cap_q.size() && i < com_q.size(); i++) begin
            n_cmp++;
            if (com_q[i] - cap_q[i] != 17 || (i > 0 && cap_q[i] - cap_q[i-1] != 24)) begin
                n_fail++;
                $display("FAIL overrun_step_%0d: commit-capture %0d expected 17, spacing %0d expected 24",
                         i, com_q[i] - cap_q[i], (i > 0) ? cap_q[i] - cap_q[i-1] : 24);
            end
        end
        n_cmp++;
        if (step_count !== 16'd4 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_end: steps %0d ovr %b expected 4 1", step_count, overrun);
        end
    endtask

    task automatic test_mid_disable();
        do_reset(8'd20);
        cfg_ready_async   = 1'b1;
        spike_ready_async = 1'b1;
        while (cyc < 29) tick();
        spike_ready_async = 1'b0;
        while (cyc < 100) tick();
        n_cmp++;
        if (com_q.size() != 1 || cap_q.size() != 1 || layer_cnt != 16) begin
            n_fail++;
            $display("FAIL middis_counts: commits %0d caps %0d layer %0d expected 1 1 16",
                     com_q.size(), cap_q.size(), layer_cnt);
        end
        n_cmp++;
        if (com_q.size() > 0 && com_q[0] != 41) begin
            n_fail++;
            $display("FAIL middis_commit_cycle: got %0d expected 41", com_q[0]);
        end
        n_cmp++;
        if (dut.state_q !== 3'd0 || busy !== 1'b0 || step_count !== 16'd1) begin
            n_fail++;
            $display("FAIL middis_idle: state %0d busy %b steps %0d expected 0 0 1",
                     dut.state_q, busy, step_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [24:0] obs;
        do_reset(8'd20);
        cfg_ready_async   = 1'b1;
        spike_ready_async = 1'b1;
        while (cyc < 30) tick();
        n_cmp++;
        if (layer_en !== 1'b1 || neuron_idx !== 3'd5) begin
            n_fail++;
            $display("FAIL rstmid_pre: en %b neuron %0d expected 1 5", layer_en, neuron_idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs = {busy, spike_capture, layer_en, state_commit, overrun, layer_sel, neuron_idx, step_count};
        n_cmp++;
        if (obs !== 25'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h expected 0", obs);
        end
        repeat (3) tick();
        n_cmp++;
        if (com_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_commit: commits %0d busy %b expected 0 0", com_q.size(), busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset(8'd20);
        force dut.step_count_q = 16'hFFFF;
        tick();
        release dut.step_count_q;
        clear_rec();
        cfg_ready_async   = 1'b1;
        spike_ready_async = 1'b1;
        while (cyc < 40) tick();
        n_cmp++;
        if (step_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_hold: got %h expected ffff", step_count);
        end
        while (cyc < 45) tick();
        n_cmp++;
        if (com_q.size() != 1 || step_count !== 16'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: commits %0d steps %h expected 1 0000", com_q.size(), step_count);
        end
    endtask

`ifdef SCHED_SINGLE_STEP_EN
    task automatic test_single_step();
        do_reset(8'd20);
        cfg_ready_async = 1'b1;
        step_req_async  = 1'b1;
        while (cyc < 3) tick();
        step_req_async = 1'b0;
        while (cyc < 10) tick();
        step_req_async = 1'b1;
        while (cyc < 13) tick();
        step_req_async = 1'b0;
        while (cyc < 40) tick();
        step_req_async = 1'b1;
        while (cyc < 43) tick();
        step_req_async = 1'b0;
        while (cyc < 80) tick();
        n_cmp++;
        if (cap_q.size() != 2 || com_q.size() != 2 || step_count !== 16'd2) begin
            n_fail++;
            $display("FAIL single_counts: caps %0d commits %0d steps %0d expected 2 2 2",
                     cap_q.size(), com_q.size(), step_count);
        end
        n_cmp++;
        if (cap_q.size() == 2 && (cap_q[0] != 3 || cap_q[1] != 43)) begin
            n_fail++;
            $display("FAIL single_timing: caps at %0d %0d expected 3 43", cap_q[0], cap_q[1]);
        end
        n_cmp++;
        if (dut.state_q !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: state %0d busy %b expected 0 0", dut.state_q, busy);
        end
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        clear_rec();
        test_reset();
        test_start();
        test_periodic();
        test_overrun();
        test_mid_disable();
        test_reset_mid();
        test_wrap();
`ifdef SCHED_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
